avg4_accum: RTL and testbench
=============================

AVG4_ACCUM -- requirements
Module: avg4_accum

Interface
REQ-001 SHALL have one clock and one reset: clock clk, reset rst_n, synchronous, active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 in_valid  input  1  in_data holds a sample.
REQ-005 in_ready  output  1  block accepts a sample this cycle.
REQ-006 in_data  input  4  unsigned sample, 0..15.
REQ-007 flush  input  1  discard the partial batch.
REQ-008 out_valid  output  1  the result outputs hold a result.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_avg  output  4  floor(sum/4).
REQ-011 out_rem  output  2  sum mod 4.
REQ-012 batch_cnt  output  8  count of completed output handshakes.

Function
REQ-013 SHALL be an FSM with two states:
- COLLECT: accepting samples.
- OUT: holding a result.
REQ-014 Counters and accumulator:
- sample counter cnt: 2 bits.
- accumulator sum: 6 bits (max 4*15=60, no overflow).
REQ-015 SHALL drive in_ready=1 exactly when state=COLLECT, combinationally from state only.
REQ-016 Accept = in_valid & in_ready: sum+=in_data and cnt+=1 on that clock edge.
REQ-017 On the 4th accept (cnt=3):
- next cycle state=OUT and out_valid=1.
- out_avg=(sum+in_data)>>2 and out_rem=(sum+in_data)[1:0], both registered.
- cnt and sum clear to 0.
REQ-018 Latency SHALL be one cycle from the 4th accept edge to out_valid=1; no combinational path from in_data to the result outputs.
REQ-019 In OUT, SHALL hold out_valid, out_avg and out_rem stable until out_valid & out_ready.
REQ-020 On the output handshake:
- next state=COLLECT, out_valid=0.
- batch_cnt+=1, wrapping 255->0.
- out_avg/out_rem keep their last value.
REQ-021 In OUT, in_valid SHALL be ignored; minimum period is 5 cycles per batch.
REQ-022 flush=1 in COLLECT SHALL clear cnt and sum next cycle. Flush has priority over a simultaneous accept: the handshake completes but the sample is discarded.
REQ-023 flush=1 in OUT SHALL be ignored; the pending result is preserved.
REQ-024 flush on a 4th-accept cycle SHALL discard the batch: no OUT transition, no result produced.
REQ-025 The divide SHALL be a 2-bit right shift; no divide operator.

Reset
REQ-026 While rst_n=0 at a rising edge, the next state SHALL be:
- state=COLLECT, cnt=0, sum=0.
- out_valid=0, out_avg=0, out_rem=0, batch_cnt=0.
REQ-027 Reset mid-batch or in OUT SHALL discard all partial and pending data; in_ready=1 on the first cycle after reset.

Structure
REQ-028 Shared package avg4_pkg SHALL hold:
- state enum type (COLLECT, OUT).
- constants SAMPLE_W=4, SUM_W=6, BATCH_N=4, BCNT_W=8.
REQ-029 SHALL contain one sub-module, avg4_shift: combinational 6-bit sum -> 4-bit avg + 2-bit rem.
REQ-030 All other logic (FSM, counters, output registers) SHALL live in avg4_accum.

Verification
REQ-031 Reset: rst_n=0 for 2 cycles, then release -> out_valid=0, in_ready=1, out_avg=0, out_rem=0, batch_cnt=0.
REQ-032 Back-to-back samples 3,5,7,9 with out_ready=1 -> out_valid=1 the cycle after the 9 is accepted, out_avg=6, out_rem=0; next cycle batch_cnt=1, in_ready=1.
REQ-033 Boundary values:
- 15,15,15,15 -> out_avg=15, out_rem=0.
- 1,0,0,2 -> out_avg=0, out_rem=3.
REQ-034 Backpressure: samples 2,2,2,3 with out_ready=0 for 5 cycles and in_valid=1 throughout -> in_ready=0, out_avg=2, out_rem=1 held stable; no sample accepted until out_ready=1.
REQ-035 Flush and wrap:
- 4,4 then flush, then 8,8,8,8 -> out_avg=8, out_rem=0.
- reset after 2 samples -> no result produced.
- 256 completed batches -> batch_cnt=0.

Source files
------------

// File: rtl/avg4_pkg.sv
// Shared types and widths for the four-sample averaging accumulator.
package avg4_pkg;

  localparam int SAMPLE_W = 4;
  localparam int SUM_W    = 6;
  localparam int BATCH_N  = 4;
  localparam int BCNT_W   = 8;
  localparam int CNT_W    = 2;
  localparam int REM_W    = 2;

  typedef enum logic {
    COLLECT = 1'b0,
    OUT     = 1'b1
  } state_e;

endpackage

// File: rtl/avg4_shift.sv
// Splits a batch sum into floor(sum/4) and sum mod 4 with a plain 2-bit shift.
module avg4_shift
  import avg4_pkg::*;
(
  input  logic [SUM_W-1:0]    sum,
  output logic [SAMPLE_W-1:0] avg,
  output logic [REM_W-1:0]    rem
);

  assign avg = sum[SUM_W-1:REM_W];
  assign rem = sum[REM_W-1:0];

endmodule

// File: rtl/avg4_accum.sv
// Collects four 4-bit samples, then presents their average and remainder
// on a valid/ready output until the downstream side takes it.
module avg4_accum
  import avg4_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_avg,
  output logic [REM_W-1:0]    out_rem,
  output logic [BCNT_W-1:0]   batch_cnt
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                out_valid_q, out_valid_d;
  logic [SAMPLE_W-1:0] out_avg_q, out_avg_d;
  logic [REM_W-1:0]    out_rem_q, out_rem_d;
  logic [BCNT_W-1:0]   batch_cnt_q, batch_cnt_d;

  logic                accept;
  logic [SUM_W-1:0]    sum_next;
  logic [SAMPLE_W-1:0] avg_next;
  logic [REM_W-1:0]    rem_next;

  assign in_ready = (state_q == COLLECT);
  assign accept   = in_valid & in_ready;
  assign sum_next = sum_q + SUM_W'(in_data);

  avg4_shift u_shift (
    .sum (sum_next),
    .avg (avg_next),
    .rem (rem_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    out_avg_d   = out_avg_q;
    out_rem_d   = out_rem_q;
    batch_cnt_d = batch_cnt_q;
    case (state_q)
      COLLECT: begin
        // Flush wins over a same-cycle accept, including the batch-closing one.
        if (flush) begin
          cnt_d = '0;
          sum_d = '0;
        end else if (accept) begin
          if (cnt_q == CNT_W'(BATCH_N - 1)) begin
            state_d     = OUT;
            out_valid_d = 1'b1;
            out_avg_d   = avg_next;
            out_rem_d   = rem_next;
            cnt_d       = '0;
            sum_d       = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            sum_d = sum_next;
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d     = COLLECT;
          out_valid_d = 1'b0;
          batch_cnt_d = batch_cnt_q + BCNT_W'(1);
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_avg_q   <= '0;
      out_rem_q   <= '0;
      batch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_avg_q   <= out_avg_d;
      out_rem_q   <= out_rem_d;
      batch_cnt_q <= batch_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_avg   = out_avg_q;
  assign out_rem   = out_rem_q;
  assign batch_cnt = batch_cnt_q;

endmodule

// File: tb/tb_avg4_accum.sv
// Directed bench for avg4_accum with hand-computed batch results.
module tb_avg4_accum;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_avg;
  logic [1:0] out_rem;
  logic [7:0] batch_cnt;

  int n_cmp;
  int n_mis;

  avg4_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_avg   (out_avg),
    .out_rem   (out_rem),
    .batch_cnt (batch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives four samples on consecutive cycles; result is visible right after.
  task automatic feed4(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
    logic [3:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      tick();
    end
    in_valid = 1'b0;
    in_data  = 4'd0;
  endtask

  task automatic feed1(input logic [3:0] a);
    in_valid = 1'b1;
    in_data  = a;
    tick();
    in_valid = 1'b0;
    in_data  = 4'd0;
  endtask

  task automatic expect_result(input string tag, input logic [3:0] avg,
                               input logic [1:0] rem);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_avg"},   32'(out_avg),   32'(avg));
    check_eq({tag, "_rem"},   32'(out_rem),   32'(rem));
  endtask

  task automatic consume(input string tag, input logic [7:0] bcnt);
    out_ready = 1'b1;
    tick();
    check_eq({tag, "_drop"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_rdy"},  32'(in_ready),  32'd1);
    check_eq({tag, "_bcnt"}, 32'(batch_cnt), 32'(bcnt));
  endtask

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    flush     = 1'b0;
    out_ready = 1'b1;

    tick();
    tick();
    rst_n = 1'b1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_ready", 32'(in_ready),  32'd1);
    check_eq("rst_avg",   32'(out_avg),   32'd0);
    check_eq("rst_rem",   32'(out_rem),   32'd0);
    check_eq("rst_bcnt",  32'(batch_cnt), 32'd0);

    // 3+5+7+9 = 24
    feed4(4'd3, 4'd5, 4'd7, 4'd9);
    expect_result("b2b", 4'd6, 2'd0);
    check_eq("b2b_notready", 32'(in_ready), 32'd0);
    consume("b2b", 8'd1);
    check_eq("b2b_hold_avg", 32'(out_avg), 32'd6);

    // 60 -> 15 r0
    feed4(4'd15, 4'd15, 4'd15, 4'd15);
    expect_result("max", 4'd15, 2'd0);
    consume("max", 8'd2);

    // 3 -> 0 r3
    feed4(4'd1, 4'd0, 4'd0, 4'd2);
    expect_result("small", 4'd0, 2'd3);
    consume("small", 8'd3);

    // Backpressure: 9 -> 2 r1, with in_valid and a flush pulse while held
    out_ready = 1'b0;
    feed4(4'd2, 4'd2, 4'd2, 4'd3);
    in_valid = 1'b1;
    in_data  = 4'd15;
    for (int i = 0; i < 5; i++) begin
      flush = (i == 2);
      expect_result("bp", 4'd2, 2'd1);
      check_eq("bp_ready", 32'(in_ready), 32'd0);
      tick();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    expect_result("bp_end", 4'd2, 2'd1);
    consume("bp", 8'd4);
    // Nothing leaked in during OUT: exactly four 4s give 4 r0
    feed4(4'd4, 4'd4, 4'd4, 4'd4);
    expect_result("bp_after", 4'd4, 2'd0);
    consume("bp_after", 8'd5);

    // Flush between batches
    feed1(4'd4);
    feed1(4'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    feed4(4'd8, 4'd8, 4'd8, 4'd8);
    expect_result("flush", 4'd8, 2'd0);
    consume("flush", 8'd6);

    // Flush on a simultaneous accept discards that sample
    feed1(4'd1);
    feed1(4'd1);
    flush = 1'b1;
    feed1(4'd15);
    flush = 1'b0;
    feed4(4'd5, 4'd5, 4'd5, 4'd5);
    expect_result("flush_acc", 4'd5, 2'd0);
    consume("flush_acc", 8'd7);

    // Flush on the 4th accept produces no result
    feed1(4'd7);
    feed1(4'd7);
    feed1(4'd7);
    flush = 1'b1;
    feed1(4'd7);
    flush = 1'b0;
    check_eq("flush4_noout", 32'(out_valid), 32'd0);
    check_eq("flush4_ready", 32'(in_ready),  32'd1);
    feed4(4'd6, 4'd6, 4'd6, 4'd7);
    expect_result("flush4_next", 4'd6, 2'd1);
    consume("flush4_next", 8'd8);

    // Reset mid-batch discards the partial sum
    feed1(4'd9);
    feed1(4'd9);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_ready", 32'(in_ready),  32'd1);
    check_eq("midrst_bcnt",  32'(batch_cnt), 32'd0);
    feed4(4'd3, 4'd3, 4'd3, 4'd3);
    expect_result("midrst_next", 4'd3, 2'd0);
    consume("midrst_next", 8'd1);

    // Wrap: 255 more batches brings the count from 1 back to 0
    for (int i = 0; i < 254; i++) begin
      feed4(4'd1, 4'd1, 4'd1, 4'd1);
      out_ready = 1'b1;
      tick();
    end
    check_eq("wrap_255", 32'(batch_cnt), 32'd255);
    feed4(4'd1, 4'd2, 4'd3, 4'd4);
    expect_result("wrap_last", 4'd2, 2'd2);
    consume("wrap", 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
